fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage feeding the decoder. Holds the program counter, issues word-aligned requests to the instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a small in-order queue. Presents one instruction per cycle to the decode stage through a valid/ready handshake. Accepts PC redirects from branch/jump resolution, squashing buffered and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0
- QDEPTH, 2, instruction queue entries and max in-flight-plus-buffered words; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  memory accepts request this cycle (handshake = imem_req & imem_gnt)
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 0)
- inst_valid  out  1  queue head valid
- inst  out  32  queue head instruction word (to decoder inst)
- inst_pc  out  32  PC of queue head
- inst_ready  in  1  decode consumes head (pop = inst_valid & inst_ready)

## Operation
- State: pc (32), queue of QDEPTH {word, pc} entries with rd/wr pointers and occupancy count, outstanding counter (in-flight granted requests), discard counter (in-flight responses to drop), pipeline req_pc FIFO pairing each grant with its PC (depth QDEPTH).
- Issue: imem_req = !rst & !redirect & (occupancy + outstanding − pop < QDEPTH). imem_addr = pc. On grant: pc ← pc + 4 (mod 2^32, wraps), outstanding +1, pc pushed to req_pc FIFO.
- Response: each imem_rvalid decrements outstanding and pops req_pc. If discard > 0, word dropped and discard −1; else {imem_rdata, req_pc} written to queue tail.
- Pop: on inst_valid & inst_ready, head advances.
- Redirect (priority over all else): at the edge, pc ← {redirect_pc[31:2],2'b00}, queue emptied, discard ← outstanding after this cycle's response is accounted (a response arriving in the redirect cycle is dropped). imem_req forced 0 during redirect cycle; outstanding retains in-flight count.
- Simultaneous queue write and pop allowed when full or empty; occupancy unchanged.
- imem_rvalid with outstanding == 0 is a protocol violation; ignored (no state change).

## Timing
- Reset values: pc = RESET_PC, queue empty, outstanding = 0, discard = 0; inst_valid = 0, inst = 0, inst_pc = 0, imem_req = 0 while rst high, imem_addr = RESET_PC.
- First request asserted in first cycle after rst deasserts.
- Latency (without bypass): response in cycle N → inst_valid in cycle N+1.
- With 1-cycle memory, continuous grant and inst_ready high: one instruction per cycle sustained; imem_req depends combinationally on inst_ready.
- After redirect in cycle R: first request at redirect_pc in R+1; inst_valid = 0 from R+1 until the first new response is written.
- rst asserted mid-operation: immediate return to reset values; memory must also discard in-flight responses.

## Configuration
- FETCH_BYPASS_EN defined: when queue is empty, discard = 0 and imem_rvalid is high, inst/inst_pc/inst_valid driven combinationally from imem_rdata/req_pc in the same cycle; if also popped, nothing is written to the queue. Latency response→inst_valid becomes 0 cycles.
- Undefined: all outputs come from queue registers only; latency 1 cycle.

## Test plan
- Reset with RESET_PC = 32'h0000_0100, gnt=1, 1-cycle response -> imem_addr 0x100, 0x104, 0x108 on consecutive cycles; inst_pc matches; inst_valid low during reset.
- inst_ready held low, gnt=1 -> exactly QDEPTH grants, imem_req then stays 0; raise ready -> words emerge in order, no loss/duplication.
- Redirect to 32'h0000_2003 with 2 requests in flight -> both late responses dropped, next imem_addr 0x2000, first inst_pc 0x2000.
- Redirect in same cycle as imem_rvalid and pop -> response dropped, queue empty next cycle, imem_req 0 in redirect cycle.
- pc = 32'hFFFF_FFFC granted -> next imem_addr 32'h0000_0000.
- Variable latency (gnt stalls, responses 1-4 cycles) random vs. reference PC model -> inst/inst_pc sequence exact; with FETCH_BYPASS_EN, empty-queue response visible on inst in the same cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch stage's external handshakes into one interface:
//     imem_req/imem_addr/imem_gnt      request/grant to instruction memory
//     imem_rvalid/imem_rdata           in-order responses from memory
//     redirect/redirect_pc             PC redirect from branch resolution
//     inst_valid/inst/inst_pc/inst_ready  instruction handoff to decode
//   modport master : the fetch unit side
//   modport slave  : the environment (memory + decode + branch unit)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the PC, issues word-aligned requests to
//   instruction memory, pairs each granted request with its PC in a small
//   FIFO, and buffers returned words in an in-order queue presented to decode
//   through a valid/ready handshake. A redirect restarts fetch at a new PC,
//   empties the queue and marks all in-flight responses for discard.
//
//   Ports:
//     clk  - single clock, all state on rising edge
//     rst  - asynchronous, active-high reset
//     bus  - fetch_unit_if.master (imem request/response, redirect, decode)
//
//   Parameters:
//     RESET_PC - PC of the first fetch after reset (word aligned)
//     QDEPTH   - queue entries and max in-flight-plus-buffered words
//                (power of two, >= 2)
//
//   Configuration macro:
//     FETCH_BYPASS_EN - when defined, a response arriving while the queue is
//                       empty and nothing is being discarded is presented to
//                       decode combinationally in the same cycle.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

    // Program counter
    logic [31:0]   pc_q, pc_d;

    // Instruction queue {word, pc}
    logic [31:0]   q_word_q [QDEPTH];
    logic [31:0]   q_word_d [QDEPTH];
    logic [31:0]   q_pc_q   [QDEPTH];
    logic [31:0]   q_pc_d   [QDEPTH];
    logic [AW-1:0] q_rd_q, q_rd_d;
    logic [AW-1:0] q_wr_q, q_wr_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;

    // In-flight tracking
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    // PC of each granted request, in grant order
    logic [31:0]   rp_mem_q [QDEPTH];
    logic [31:0]   rp_mem_d [QDEPTH];
    logic [AW-1:0] rp_rd_q, rp_rd_d;
    logic [AW-1:0] rp_wr_q, rp_wr_d;

    // Handshake qualifiers
    logic          rvalid_eff;
    logic          head_valid;
    logic          bypass;
    logic          pop;
    logic          q_pop;
    logic          q_write;
    logic          grant;
    logic [CW:0]   occ_next;

    // Low PC bits of a redirect target are ignored by design.
    logic          unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // A response with nothing outstanding is a protocol violation; ignore it.
    assign rvalid_eff = bus.imem_rvalid & (outst_q != '0);
    assign head_valid = (q_cnt_q != '0);

`ifdef FETCH_BYPASS_EN
    // Forward a live response straight to decode when it would otherwise land
    // in an empty queue. Suppressed during redirect since that response is
    // squashed.
    assign bypass = rvalid_eff & ~head_valid & (discard_q == '0) & ~bus.redirect;
`else
    assign bypass = 1'b0;
`endif

    // Decode-facing outputs
    always_comb begin
        bus.inst_valid = head_valid | bypass;
        if (bypass) begin
            bus.inst    = bus.imem_rdata;
            bus.inst_pc = rp_mem_q[rp_rd_q];
        end else begin
            bus.inst    = q_word_q[q_rd_q];
            bus.inst_pc = q_pc_q[q_rd_q];
        end
    end

    assign pop   = bus.inst_valid & bus.inst_ready;
    assign q_pop = pop & head_valid;

    // Space check counts buffered plus in-flight words, crediting this
    // cycle's pop so the request stream keeps up with a ready decoder.
    assign occ_next     = {1'b0, q_cnt_q} + {1'b0, outst_q} - {{CW{1'b0}}, pop};
    assign bus.imem_req = ~rst & ~bus.redirect & (occ_next < QDEPTH_W);
    assign bus.imem_addr = pc_q;
    assign grant        = bus.imem_req & bus.imem_gnt;

    // A bypassed word that decode takes this cycle is never stored.
    assign q_write = rvalid_eff & (discard_q == '0) & ~(bypass & pop);

    always_comb begin
        pc_d      = pc_q;
        q_word_d  = q_word_q;
        q_pc_d    = q_pc_q;
        q_rd_d    = q_rd_q;
        q_wr_d    = q_wr_q;
        q_cnt_d   = q_cnt_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        rp_mem_d  = rp_mem_q;
        rp_rd_d   = rp_rd_q;
        rp_wr_d   = rp_wr_q;

        // Issue
        if (grant) begin
            pc_d              = pc_q + 32'd4;
            rp_mem_d[rp_wr_q] = pc_q;
            rp_wr_d           = rp_wr_q + 1'b1;
        end
        outst_d = outst_q + {{(CW-1){1'b0}}, grant} - {{(CW-1){1'b0}}, rvalid_eff};

        // Response
        if (rvalid_eff) begin
            rp_rd_d = rp_rd_q + 1'b1;
            if (discard_q != '0) begin
                discard_d = discard_q - 1'b1;
            end
        end
        if (q_write) begin
            q_word_d[q_wr_q] = bus.imem_rdata;
            q_pc_d[q_wr_q]   = rp_mem_q[rp_rd_q];
            q_wr_d           = q_wr_q + 1'b1;
        end

        // Pop
        if (q_pop) begin
            q_rd_d = q_rd_q + 1'b1;
        end
        q_cnt_d = q_cnt_q + {{(CW-1){1'b0}}, q_write} - {{(CW-1){1'b0}}, q_pop};

        // Redirect overrides: everything still in flight (after this cycle's
        // response) becomes a word to drop.
        if (bus.redirect) begin
            pc_d      = {bus.redirect_pc[31:2], 2'b00};
            q_rd_d    = '0;
            q_wr_d    = '0;
            q_cnt_d   = '0;
            discard_d = outst_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            q_rd_q    <= '0;
            q_wr_q    <= '0;
            q_cnt_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            rp_rd_q   <= '0;
            rp_wr_q   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_word_q[i] <= '0;
                q_pc_q[i]   <= '0;
                rp_mem_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            q_word_q  <= q_word_d;
            q_pc_q    <= q_pc_d;
            q_rd_q    <= q_rd_d;
            q_wr_q    <= q_wr_d;
            q_cnt_q   <= q_cnt_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            rp_mem_q  <= rp_mem_d;
            rp_rd_q   <= rp_rd_d;
            rp_wr_q   <= rp_wr_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Drives fetch_unit with a behavioural memory (in-order responses, variable
//   latency, grant stalls) and a random decoder. Reference model: the fetch
//   address stream is a PC that steps by 4 per grant and restarts at each
//   redirect target; the decode stream must be the same PC sequence starting
//   at the last redirect/reset target, with each word a fixed function of
//   its address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          QD  = 2;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model state
    logic [31:0] model_pc;
    logic [31:0] exp_pc;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          last_due;
    bit          prev_redirect;

    // Stimulus knobs
    int gnt_pct, ready_pct, lat_min, lat_max;

    // Observation
    int          pops, grants;
    logic [31:0] gaddr[$];
    bit          arm, fg_set, fp_set, saw_zero;
    logic [31:0] fg, fp;
    logic        last_rvalid, last_pop, last_inst_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // One clock cycle; entered just after a falling edge.
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        int due;
        logic [31:0] tgt;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
        bus.inst_ready  = ($urandom_range(99) < ready_pct);
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mq_addr[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        if (prev_redirect) chk("valid_after_redirect", {31'b0, bus.inst_valid}, 32'd0);
        if (redir)         chk("req_in_redirect", {31'b0, bus.imem_req}, 32'd0);
        if (bus.imem_req)  chk("imem_addr", bus.imem_addr, model_pc);
        if (bus.inst_valid) begin
            chk("inst_pc", bus.inst_pc, exp_pc);
            chk("inst", bus.inst, mem_word(exp_pc));
        end
        last_rvalid     = bus.imem_rvalid;
        last_inst_valid = bus.inst_valid;
        last_pop        = bus.inst_valid & bus.inst_ready;

        if (bus.inst_valid && bus.inst_ready) begin
            if (arm && !fp_set) begin fp = exp_pc; fp_set = 1'b1; end
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (bus.imem_req && bus.imem_gnt) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(model_pc);
            mq_due.push_back(due);
            gaddr.push_back(model_pc);
            if (arm && !fg_set) begin fg = model_pc; fg_set = 1'b1; end
            if (model_pc == 32'h0) saw_zero = 1'b1;
            model_pc = model_pc + 32'd4;
            grants++;
        end
        if (bus.imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (redir) begin
            tgt      = {rpc[31:2], 2'b00};
            model_pc = tgt;
            exp_pc   = tgt;
        end
        prev_redirect = redir;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        rst             = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
            chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
            chk("rst_imem_addr", bus.imem_addr, RPC);
            chk("rst_inst", bus.inst, 32'd0);
            chk("rst_inst_pc", bus.inst_pc, 32'd0);
            cyc++;
        end
        mq_addr.delete();
        mq_due.delete();
        last_due      = cyc;
        model_pc      = RPC;
        exp_pc        = RPC;
        prev_redirect = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_req_after_rst", {31'b0, bus.imem_req}, 32'd1);
    endtask

    initial begin
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
        pops = 0; grants = 0; arm = 0; fg_set = 0; fp_set = 0; saw_zero = 0;
        fg = 0; fp = 0;

        // Reset, then sequential addresses with 1-cycle memory
        do_reset(3);
        gaddr.delete();
        run(3);
        chk("addr0", gaddr[0], 32'h0000_0100);
        chk("addr1", gaddr[1], 32'h0000_0104);
        chk("addr2", gaddr[2], 32'h0000_0108);
        pops = 0;
        run(10);
        chk("throughput_pops", pops, 32'd10);

        // Decoder stalled: exactly QDEPTH grants after emptying via redirect
        ready_pct = 0;
        cycle(1'b1, 32'h0000_4000);
        grants = 0;
        run(8);
        chk("stall_grants", grants, QD);
        chk("stall_req_low", {31'b0, bus.imem_req}, 32'd0);
        ready_pct = 100;
        pops = 0;
        run(6);
        chk("stall_drain", {31'b0, (pops >= QD)}, 32'd1);

        // Redirect with two requests in flight
        lat_min = 4; lat_max = 4;
        cycle(1'b1, 32'h0000_3000);
        run(2);
        chk("inflight_two", mq_addr.size(), 32'd2);
        arm = 1; fg_set = 0; fp_set = 0;
        cycle(1'b1, 32'h0000_2003);
        run(12);
        arm = 0;
        chk("redir_first_addr", fg, 32'h0000_2000);
        chk("redir_first_pop_seen", {31'b0, fp_set}, 32'd1);
        chk("redir_first_inst_pc", fp, 32'h0000_2000);

        // Redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        run(5);
        cycle(1'b1, 32'h0000_3000);
        chk("redir_cycle_rvalid", {31'b0, last_rvalid}, 32'd1);
        chk("redir_cycle_pop", {31'b0, last_pop}, 32'd1);
        run(4);

        // PC wrap
        cycle(1'b1, 32'hFFFF_FFF8);
        run(8);
        chk("pc_wrap_zero", {31'b0, saw_zero}, 32'd1);

        // Single response into an empty queue: same-cycle visibility only with bypass
        gnt_pct = 0; lat_min = 2; lat_max = 2;
        cycle(1'b1, 32'h0000_5000);
        run(6);
        gnt_pct = 100;
        cycle(1'b0, 32'h0);
        gnt_pct = 0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 6 && !seen; i++) begin
                cycle(1'b0, 32'h0);
                if (last_rvalid) seen = 1'b1;
            end
            chk("bypass_resp_seen", {31'b0, seen}, 32'd1);
            chk("bypass_same_cycle", {31'b0, last_inst_valid}, {31'b0, BYP});
        end
        run(3);

        // Random traffic with redirects and one mid-run reset
        gnt_pct = 70; ready_pct = 70; lat_min = 1; lat_max = 4;
        pops = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                do_reset(2);
            end else if ($urandom_range(99) < 3) begin
                cycle(1'b1, $urandom);
            end else begin
                cycle(1'b0, 32'h0);
            end
        end
        chk("random_progress", {31'b0, (pops > 100)}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
